// File: rtl/fifo_rd_stream_if.sv
// Bus bundle between the async FIFO read side and the stream consumer.
// m_valid/m_ready handshake: a word transfers on a rising rd_clk edge where both m_valid and
// m_ready are high; once raised, m_valid and m_data hold until that transfer, and m_ready may
// be driven freely (including combinationally) by the consumer.
interface fifo_rd_stream_if #(
  parameter int DSIZE = 8
);
  logic             rd_empty;
  logic [DSIZE-1:0] rd_data;
  logic             rd_inc;
  logic             m_valid;
  logic             m_ready;
  logic [DSIZE-1:0] m_data;
  logic [1:0]       m_count;

  modport master (
    input  rd_empty, rd_data, m_ready,
    output rd_inc, m_valid, m_data, m_count
  );

  modport slave (
    output rd_empty, rd_data, m_ready,
    input  rd_inc, m_valid, m_data, m_count
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// Read-side FIFO consumer: issues rd_inc while words are available and turns the 1-cycle
// latency memory read port into a valid/ready stream through a 2-entry skid buffer.
module fifo_rd_stream #(
  parameter int DSIZE = 8
) (
  input  logic              rd_clk,
  input  logic              rd_rst,
  fifo_rd_stream_if.master  bus
);

  logic [1:0]       r_occ;
  logic             r_pend;
  logic             r_head;
  logic             r_tail;
  logic [DSIZE-1:0] r_buf [2];

  logic             w_pop;
  logic [2:0]       w_level;
  logic             w_inc;

  assign w_pop   = (r_occ != 2'd0) && bus.m_ready;
  // Words held plus the one in flight, minus the one leaving now; pop implies occ >= 1.
  assign w_level = {1'b0, r_occ} + {2'b00, r_pend} - {2'b00, w_pop};
  assign w_inc   = !rd_rst && !bus.rd_empty && (w_level < 3'd2);

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      r_occ    <= 2'd0;
      r_pend   <= 1'b0;
      r_head   <= 1'b0;
      r_tail   <= 1'b0;
      r_buf[0] <= '0;
      r_buf[1] <= '0;
    end else begin
      r_pend <= w_inc;
      if (r_pend) begin
        r_buf[r_tail] <= bus.rd_data;
        r_tail        <= ~r_tail;
      end
      if (w_pop) begin
        r_head <= ~r_head;
      end
      case ({r_pend, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign bus.rd_inc  = w_inc;
  assign bus.m_valid = (r_occ != 2'd0);
  assign bus.m_data  = r_buf[r_head];
  assign bus.m_count = r_occ;

endmodule
